// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - shared constants and FSM state codes for the frame burst loader
package frame_pkg;

    localparam int DATA_W_DEF      = 16;
    localparam int FRAME_WORDS_DEF = 1024;
    localparam int ADDR_W_DEF      = 10;
    localparam int CSUM_W          = 16;

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_START   = 2'd2;
    localparam logic [1:0] ST_BURST   = 2'd3;

endpackage

// File: rtl/frame_buffer.sv
// rtl/frame_buffer.sv - simple dual-port frame RAM, synchronous write and 1-cycle synchronous read
module frame_buffer
    import frame_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = FRAME_WORDS_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/frame_burst_loader.sv
// rtl/frame_burst_loader.sv - assembles rx bytes into a frame buffer and bursts full frames downstream
// Optional trailing checksum word and frame_error port: FRAME_BURST_LOADER_CHECKSUM_EN
module frame_burst_loader
    import frame_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int FRAME_WORDS = FRAME_WORDS_DEF,
    parameter int ADDR_W      = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              frame_release,
    output logic [DATA_W-1:0] com_data_in,
    output logic              data_write_start,
    output logic              data_write_done,
    output logic              overrun
`ifdef FRAME_BURST_LOADER_CHECKSUM_EN
    ,output logic             frame_error
`endif
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

    logic [1:0]        state, state_nx;
    logic              phase;
    logic [7:0]        low_byte;
    logic [ADDR_W-1:0] wr_cnt, rd_cnt, rd_addr;
    logic              dn_free;
    logic [DATA_W-1:0] word, rd_data;
    logic              accept, word_done, wr_en, last_word, frame_end, csum_ok, released, rd_en;

    assign accept    = rx_valid && rx_ready;
    assign word_done = accept && phase;
    assign word      = {rx_byte, low_byte};
    assign last_word = wr_en && (wr_cnt == LAST_ADDR);
    assign released  = dn_free || frame_release;

`ifdef FRAME_BURST_LOADER_CHECKSUM_EN
    logic              csum_phase;
    logic [CSUM_W-1:0] sum;

    // The word after the last data word is the checksum and is never stored.
    assign wr_en     = word_done && !csum_phase;
    assign frame_end = word_done && csum_phase;
    assign csum_ok   = (CSUM_W'(word) == sum);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_phase  <= 1'b0;
            sum         <= '0;
            frame_error <= 1'b0;
        end else begin
            frame_error <= frame_end && !csum_ok;
            if (frame_end) begin
                csum_phase <= 1'b0;
                sum        <= '0;
            end else if (wr_en) begin
                sum <= sum + CSUM_W'(word);
                if (last_word) csum_phase <= 1'b1;
            end
        end
    end
`else
    assign wr_en     = word_done;
    assign frame_end = last_word;
    assign csum_ok   = 1'b1;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            ST_COLLECT: if (frame_end && csum_ok) state_nx = released ? ST_START : ST_HOLD;
            ST_HOLD:    if (released) state_nx = ST_START;
            ST_START:   state_nx = ST_BURST;
            ST_BURST:   if (rd_cnt == LAST_ADDR) state_nx = ST_COLLECT;
            default:    state_nx = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_COLLECT;
            rx_ready <= 1'b0;
            phase    <= 1'b0;
            low_byte <= '0;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            dn_free  <= 1'b1;
            overrun  <= 1'b0;
        end else begin
            state    <= state_nx;
            rx_ready <= (state_nx == ST_COLLECT);
            if (state != ST_COLLECT) phase <= 1'b0;
            else if (accept)         phase <= ~phase;
            if (accept && !phase) low_byte <= rx_byte;
            if (wr_en) wr_cnt <= last_word ? '0 : wr_cnt + 1'b1;
            if (state == ST_START)      rd_cnt <= '0;
            else if (state == ST_BURST) rd_cnt <= rd_cnt + 1'b1;
            // START claims the downstream; a release in that same cycle is lost.
            if (state == ST_START)  dn_free <= 1'b0;
            else if (frame_release) dn_free <= 1'b1;
            if (rx_valid && !rx_ready) overrun <= 1'b1;
        end
    end

    // Read one address ahead so word k leaves the RAM register in burst cycle k.
    assign rd_en   = (state == ST_START) || (state == ST_BURST);
    assign rd_addr = (state == ST_START) ? '0 : rd_cnt + 1'b1;

    frame_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (FRAME_WORDS),
        .ADDR_W (ADDR_W)
    ) u_buffer (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_cnt),
        .wr_data (word),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign data_write_start = (state == ST_START);
    assign com_data_in      = (state == ST_BURST) ? rd_data : '0;
    assign data_write_done  = (state == ST_BURST) && (rd_cnt == LAST_ADDR);

endmodule
